ks_datapath_p: RTL

KS_DATAPATH_P -- requirements
Module: ks_datapath_p

---
 rtl/ks_pkg.sv | 79 +++++++
 rtl/ks_alu.sv | 68 ++++++
 rtl/ks_datapath_p.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ks_pkg.sv
// ks_pkg -- shared types and constants for the ks_datapath_p datapath.
//   decoded_instruction_type : decoded IR opcode (values equal the raw opcode)
//   alu_op_type              : ALU operation select
//   OPC_*                    : raw 4-bit opcode constants
//   decode_opcode()          : raw opcode -> decoded_instruction_type
package ks_pkg;

    typedef enum logic [3:0] {
        I_NOP    = 4'h0,
        I_LOAD   = 4'h1,
        I_STORE  = 4'h2,
        I_MOVE   = 4'h3,
        I_ADD    = 4'h4,
        I_SUB    = 4'h5,
        I_AND    = 4'h6,
        I_OR     = 4'h7,
        I_XOR    = 4'h8,
        I_SHL    = 4'h9,
        I_SHR    = 4'hA,
        I_BRANCH = 4'hB,
        I_BZERO  = 4'hC,
        I_BNEG   = 4'hD,
        I_BOV    = 4'hE,
        I_HALT   = 4'hF
    } decoded_instruction_type;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'd0,
        ALU_SUB    = 3'd1,
        ALU_AND    = 3'd2,
        ALU_OR     = 3'd3,
        ALU_XOR    = 3'd4,
        ALU_SHL1   = 3'd5,
        ALU_SHR1   = 3'd6,
        ALU_PASS_A = 3'd7
    } alu_op_type;

    localparam logic [3:0] OPC_NOP    = 4'h0;
    localparam logic [3:0] OPC_LOAD   = 4'h1;
    localparam logic [3:0] OPC_STORE  = 4'h2;
    localparam logic [3:0] OPC_MOVE   = 4'h3;
    localparam logic [3:0] OPC_ADD    = 4'h4;
    localparam logic [3:0] OPC_SUB    = 4'h5;
    localparam logic [3:0] OPC_AND    = 4'h6;
    localparam logic [3:0] OPC_OR     = 4'h7;
    localparam logic [3:0] OPC_XOR    = 4'h8;
    localparam logic [3:0] OPC_SHL    = 4'h9;
    localparam logic [3:0] OPC_SHR    = 4'hA;
    localparam logic [3:0] OPC_BRANCH = 4'hB;
    localparam logic [3:0] OPC_BZERO  = 4'hC;
    localparam logic [3:0] OPC_BNEG   = 4'hD;
    localparam logic [3:0] OPC_BOV    = 4'hE;
    localparam logic [3:0] OPC_HALT   = 4'hF;

    function automatic decoded_instruction_type decode_opcode(input logic [3:0] opc);
        decoded_instruction_type d;
        case (opc)
            OPC_NOP:    d = I_NOP;
            OPC_LOAD:   d = I_LOAD;
            OPC_STORE:  d = I_STORE;
            OPC_MOVE:   d = I_MOVE;
            OPC_ADD:    d = I_ADD;
            OPC_SUB:    d = I_SUB;
            OPC_AND:    d = I_AND;
            OPC_OR:     d = I_OR;
            OPC_XOR:    d = I_XOR;
            OPC_SHL:    d = I_SHL;
            OPC_SHR:    d = I_SHR;
            OPC_BRANCH: d = I_BRANCH;
            OPC_BZERO:  d = I_BZERO;
            OPC_BNEG:   d = I_BNEG;
            OPC_BOV:    d = I_BOV;
            OPC_HALT:   d = I_HALT;
            default:    d = I_NOP;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ks_alu.sv
// ks_alu -- combinational ALU with raw status flags.
//   a, b              in  DATA_W  operands
//   operation         in  3       alu_op_type encoding
//   result            out DATA_W  truncated result
//   zero, neg         out 1       result == 0, result MSB
//   unsigned_overflow out 1       ADD carry-out / SUB borrow, else 0
//   signed_overflow   out 1       two's-complement overflow for ADD/SUB, else 0
module ks_alu
    import ks_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        operation,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              neg,
    output logic              unsigned_overflow,
    output logic              signed_overflow
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W:0]   sum_s;
    logic [DATA_W:0]   diff_s;
    logic [DATA_W-1:0] result_s;
    logic              uov_s;
    logic              sov_s;
    alu_op_type        op_s;

    assign op_s = alu_op_type'(operation);

    // Operation select; the extra top bit of sum/diff is carry-out / borrow.
    always_comb begin
        sum_s    = {1'b0, a} + {1'b0, b};
        diff_s   = {1'b0, a} - {1'b0, b};
        result_s = a;
        uov_s    = 1'b0;
        sov_s    = 1'b0;
        case (op_s)
            ALU_ADD: begin
                result_s = sum_s[DATA_W-1:0];
                uov_s    = sum_s[DATA_W];
                sov_s    = (a[MSB] == b[MSB]) && (sum_s[MSB] != a[MSB]);
            end
            ALU_SUB: begin
                result_s = diff_s[DATA_W-1:0];
                uov_s    = diff_s[DATA_W];
                sov_s    = (a[MSB] != b[MSB]) && (diff_s[MSB] != a[MSB]);
            end
            ALU_AND:    result_s = a & b;
            ALU_OR:     result_s = a | b;
            ALU_XOR:    result_s = a ^ b;
            ALU_SHL1:   result_s = {a[DATA_W-2:0], 1'b0};
            ALU_SHR1:   result_s = {1'b0, a[DATA_W-1:1]};
            ALU_PASS_A: result_s = a;
            default:    result_s = a;
        endcase
    end

    assign result            = result_s;
    assign zero              = (result_s == {DATA_W{1'b0}});
    assign neg               = result_s[MSB];
    assign unsigned_overflow = uov_s;
    assign signed_overflow   = sov_s;

endmodule

// File: rtl/ks_datapath_p.sv
// ks_datapath_p -- accumulator-less register datapath: PC, IR, register file,
// flag register and ALU, all sequenced by external strobes.
//   clk, rst_n                      clock, synchronous active-low reset
//   branch                          PC load source (IR addr field / PC+1)
//   pc_enable, ir_enable,
//   write_reg_enable, flags_enable  update strobes
//   addr_sel                        addr_ram source (0 PC, 1 IR addr field)
//   c_sel                           register write data (0 ALU, 1 data_out)
//   operation                       ALU op
//   decoded_instruction             decoded IR opcode (combinational)
//   zero, neg, unsigned_overflow,
//   signed_overflow                 registered flags
//   data_out / data_in / addr_ram   RAM read data / write data / address
module ks_datapath_p
    import ks_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int REG_CNT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    branch,
    input  logic                    pc_enable,
    input  logic                    ir_enable,
    input  logic                    write_reg_enable,
    input  logic                    flags_enable,
    input  logic                    addr_sel,
    input  logic                    c_sel,
    input  logic [2:0]              operation,
    output decoded_instruction_type decoded_instruction,
    output logic                    zero,
    output logic                    neg,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow,
    input  logic [DATA_W-1:0]       data_out,
    output logic [DATA_W-1:0]       data_in,
    output logic [ADDR_W-1:0]       addr_ram
);

    localparam int RSEL_W = $clog2(REG_CNT);

    // Reject parameter sets whose IR fields would overlap or overflow.
    if ((ADDR_W > DATA_W - 4 - RSEL_W) || (3 * RSEL_W > DATA_W - 4) ||
        (REG_CNT < 2) || ((REG_CNT & (REG_CNT - 1)) != 0)) begin : g_bad_params
        $error("ks_datapath_p: illegal DATA_W/ADDR_W/REG_CNT combination");
    end

    logic [ADDR_W-1:0] pc_r;
    logic [DATA_W-1:0] ir_r;
    logic [DATA_W-1:0] regs_r [REG_CNT];
    logic              zero_r;
    logic              neg_r;
    logic              uov_r;
    logic              sov_r;

    logic [3:0]        opcode_s;
    logic [RSEL_W-1:0] rc_s;
    logic [RSEL_W-1:0] ra_s;
    logic [RSEL_W-1:0] rb_s;
    logic [ADDR_W-1:0] addr_s;
    logic [ADDR_W-1:0] pc_inc_s;
    logic [DATA_W-1:0] alu_result_s;
    logic [DATA_W-1:0] wr_data_s;
    logic              alu_zero_s;
    logic              alu_neg_s;
    logic              alu_uov_s;
    logic              alu_sov_s;
    logic              unused_ir_bits_s;

    assign opcode_s = ir_r[DATA_W-1 -: 4];
    assign rc_s     = ir_r[DATA_W-5 -: RSEL_W];
    assign ra_s     = ir_r[RSEL_W-1:0];
    assign rb_s     = ir_r[2*RSEL_W-1 -: RSEL_W];
    assign addr_s   = ir_r[ADDR_W-1:0];
    // Some IR bits may belong to no field for a given parameter set.
    assign unused_ir_bits_s = ^ir_r;

    assign pc_inc_s  = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign wr_data_s = c_sel ? data_out : alu_result_s;

    ks_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a                 (regs_r[ra_s]),
        .b                 (regs_r[rb_s]),
        .operation         (operation),
        .result            (alu_result_s),
        .zero              (alu_zero_s),
        .neg               (alu_neg_s),
        .unsigned_overflow (alu_uov_s),
        .signed_overflow   (alu_sov_s)
    );

    // Program counter and instruction register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r <= {ADDR_W{1'b0}};
            ir_r <= {DATA_W{1'b0}};
        end else begin
            if (pc_enable) begin
                pc_r <= branch ? addr_s : pc_inc_s;
            end
            if (ir_enable) begin
                ir_r <= data_out;
            end
        end
    end

    // Register file: one write port at rc, ALU reads see pre-edge contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (write_reg_enable) begin
            regs_r[rc_s] <= wr_data_s;
        end
    end

    // Flag register: captures the ALU's raw flags only when strobed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_r <= 1'b0;
            neg_r  <= 1'b0;
            uov_r  <= 1'b0;
            sov_r  <= 1'b0;
        end else if (flags_enable) begin
            zero_r <= alu_zero_s;
            neg_r  <= alu_neg_s;
            uov_r  <= alu_uov_s;
            sov_r  <= alu_sov_s;
        end
    end

    assign decoded_instruction = decode_opcode(opcode_s);
    assign addr_ram            = addr_sel ? addr_s : pc_r;
    assign data_in             = regs_r[rc_s];
    assign zero                = zero_r;
    assign neg                 = neg_r;
    assign unsigned_overflow   = uov_r;
    assign signed_overflow     = sov_r;

endmodule
